// File: rtl/reg_bank_arbiter.sv
// Round-robin two-requester arbiter for a bank of W-bit registers.
// Latches the winning request, runs one EXEC cycle, then acks in RESP.
module reg_bank_arbiter #(
    parameter int W  = 8,
    parameter int AW = 2,
    localparam int NREG = 2 ** AW
) (
    input  logic              clk,
    input  logic              res,
    input  logic              reqA,
    input  logic              reqB,
    input  logic              weA,
    input  logic              weB,
    input  logic [AW-1:0]     addrA,
    input  logic [AW-1:0]     addrB,
    input  logic [W-1:0]      wdataA,
    input  logic [W-1:0]      wdataB,
    output logic              ackA,
    output logic              ackB,
    output logic [W-1:0]      rdata,
    output logic              busy,
    output logic [NREG-1:0]   reg_en,
    output logic [W-1:0]      reg_din,
    input  logic [NREG*W-1:0] reg_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic            prio;
    logic            win;
    logic            we_q;
    logic            wr_pend;
    logic [AW-1:0]   addr_q;
    logic [W-1:0]    wdata_q;

    logic            gnt;
    logic            gnt_we;
    logic [AW-1:0]   gnt_addr;
    logic [W-1:0]    gnt_wdata;
    logic [W-1:0]    sel_q;

    // Pick the winner: a lone requester wins, contention goes to prio (0 = A).
    always_comb begin
        gnt = 1'b0;
        if (reqA && reqB)
            gnt = prio;
        else if (reqB)
            gnt = 1'b1;
        gnt_we    = gnt ? weB    : weA;
        gnt_addr  = gnt ? addrB  : addrA;
        gnt_wdata = gnt ? wdataB : wdataA;
    end

    // Select the addressed bank register for a read capture.
    always_comb begin
        sel_q = '0;
        for (int i = 0; i < NREG; i++) begin
            if (addr_q == AW'(i))
                sel_q = reg_q[i*W +: W];
        end
    end

    // Transaction FSM with registered ack, busy and read data.
    always_ff @(posedge clk) begin
        if (res) begin
            state   <= IDLE;
            prio    <= 1'b0;
            win     <= 1'b0;
            we_q    <= 1'b0;
            wr_pend <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ackA    <= 1'b0;
            ackB    <= 1'b0;
            rdata   <= '0;
            busy    <= 1'b0;
        end else begin
            ackA    <= 1'b0;
            ackB    <= 1'b0;
            wr_pend <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (reqA || reqB) begin
                        win     <= gnt;
                        we_q    <= gnt_we;
                        wr_pend <= gnt_we;
                        addr_q  <= gnt_addr;
                        wdata_q <= gnt_wdata;
                        busy    <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (!we_q)
                        rdata <= sel_q;
                    ackA  <= !win;
                    ackB  <= win;
                    state <= RESP;
                end
                RESP: begin
                    prio  <= !win;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Reset kills an in-flight write combinationally.
    assign reg_en  = (wr_pend && !res) ? (NREG'(1) << addr_q) : '0;
    assign reg_din = wdata_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter with a behavioural register bank
// and an ack scoreboard.
module tb_reg_bank_arbiter;

    logic        clk;
    logic        res;
    logic        reqA, reqB;
    logic        weA, weB;
    logic [1:0]  addrA, addrB;
    logic [7:0]  wdataA, wdataB;
    logic        ackA, ackB;
    logic [7:0]  rdata;
    logic        busy;
    logic [3:0]  reg_en;
    logic [7:0]  reg_din;
    logic [31:0] reg_q;
    logic        bank_clr;
    logic [7:0]  bank [4];

    typedef struct packed {
        logic       who;
        logic       chk;
        logic [7:0] rd;
    } exp_t;

    exp_t sb [$];
    int   checks;
    int   failures;
    int   acks;

    reg_bank_arbiter #(.W(8), .AW(2)) dut (
        .clk(clk), .res(res),
        .reqA(reqA), .reqB(reqB),
        .weA(weA), .weB(weB),
        .addrA(addrA), .addrB(addrB),
        .wdataA(wdataA), .wdataB(wdataB),
        .ackA(ackA), .ackB(ackB),
        .rdata(rdata), .busy(busy),
        .reg_en(reg_en), .reg_din(reg_din),
        .reg_q(reg_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural bank of enable registers.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bank_clr)
                bank[i] <= 8'h00;
            else if (reg_en[i])
                bank[i] <= reg_din;
        end
    end

    assign reg_q = {bank[3], bank[2], bank[1], bank[0]};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic who, input logic c, input logic [7:0] rd);
        exp_t e;
        e.who = who;
        e.chk = c;
        e.rd  = rd;
        sb.push_back(e);
    endtask

    // Scoreboard: every ack must match the next expected transaction.
    always @(negedge clk) begin
        if (!res && (ackA || ackB)) begin
            exp_t e;
            acks++;
            chk("sb_one_ack", {30'd0, ackA, ackB}, {30'd0, !ackB, !ackA});
            if (sb.size() == 0) begin
                chk("sb_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_who", {31'd0, ackB}, {31'd0, e.who});
                if (e.chk)
                    chk("sb_rdata", {24'd0, rdata}, {24'd0, e.rd});
            end
        end
    end

    initial begin
        checks = 0; failures = 0; acks = 0;
        res = 1'b1; bank_clr = 1'b1;
        reqA = 0; reqB = 0; weA = 0; weB = 0;
        addrA = 0; addrB = 0; wdataA = 0; wdataB = 0;
        tick(); tick();
        chk("rst_ackA", {31'd0, ackA}, 0);
        chk("rst_ackB", {31'd0, ackB}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rdata", {24'd0, rdata}, 0);
        chk("rst_din", {24'd0, reg_din}, 0);
        chk("rst_en", {28'd0, reg_en}, 0);
        res = 1'b0; bank_clr = 1'b0;

        // A writes reg 2
        reqA = 1; weA = 1; addrA = 2; wdataA = 8'hA5;
        push(0, 0, 0);
        tick();
        chk("t1_en", {28'd0, reg_en}, 4'b0100);
        chk("t1_din", {24'd0, reg_din}, 8'hA5);
        chk("t1_busy", {31'd0, busy}, 1);
        chk("t1_noack", {31'd0, ackA}, 0);
        reqA = 0;
        tick();
        chk("t1_ackA", {31'd0, ackA}, 1);
        chk("t1_bank2", {24'd0, bank[2]}, 8'hA5);
        chk("t1_en_off", {28'd0, reg_en}, 0);
        tick();
        chk("t1_idle", {31'd0, busy}, 0);

        // B reads reg 2
        reqB = 1; weB = 0; addrB = 2;
        push(1, 1, 8'hA5);
        tick();
        chk("t2_en", {28'd0, reg_en}, 0);
        reqB = 0;
        tick();
        chk("t2_ackB", {31'd0, ackB}, 1);
        chk("t2_ackA", {31'd0, ackA}, 0);
        chk("t2_rdata", {24'd0, rdata}, 8'hA5);
        chk("t2_en_off", {28'd0, reg_en}, 0);
        tick();

        // Both held from reset, alternating grants
        res = 1; reqA = 1; reqB = 1; weA = 1; weB = 1;
        addrA = 0; addrB = 0; wdataA = 8'h11; wdataB = 8'h22;
        tick();
        res = 0;
        push(0, 0, 0); push(1, 0, 0); push(0, 0, 0); push(1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("t3_ackA_%0d", i), {31'd0, ackA},
                {31'd0, (i == 1 || i == 7)});
            chk($sformatf("t3_ackB_%0d", i), {31'd0, ackB},
                {31'd0, (i == 4 || i == 10)});
            if (i == 1 || i == 7)
                chk("t3_bank0_a", {24'd0, bank[0]}, 8'h11);
            if (i == 4 || i == 10)
                chk("t3_bank0_b", {24'd0, bank[0]}, 8'h22);
        end
        reqA = 0; reqB = 0;

        // B alone, then contention -> A, then B, then B alone again
        reqB = 1; weB = 1; addrB = 1; wdataB = 8'h5B;
        weA = 1; addrA = 1; wdataA = 8'h3C;
        push(1, 0, 0); push(0, 0, 0); push(1, 0, 0); push(1, 0, 0);
        tick(); tick();
        chk("t4_b1", {31'd0, ackB}, 1);
        reqA = 1;
        tick();
        chk("t4_idle1", {31'd0, busy}, 0);
        tick();
        chk("t4_a_din", {24'd0, reg_din}, 8'h3C);
        tick();
        chk("t4_a_ack", {31'd0, ackA}, 1);
        tick(); tick();
        chk("t4_b_din", {24'd0, reg_din}, 8'h5B);
        tick();
        chk("t4_b2", {31'd0, ackB}, 1);
        reqA = 0;
        tick();
        chk("t4_idle2", {31'd0, busy}, 0);
        tick();
        chk("t4_b3_busy", {31'd0, busy}, 1);
        chk("t4_b3_en", {28'd0, reg_en}, 4'b0010);
        tick();
        chk("t4_b3", {31'd0, ackB}, 1);
        reqB = 0;
        tick();
        chk("t4_bank1", {24'd0, bank[1]}, 8'h5B);

        // A reads reg 2 so prio points at B
        reqA = 1; weA = 0; addrA = 2;
        push(0, 1, 8'hA5);
        tick();
        reqA = 0;
        tick();
        chk("t5_rd", {24'd0, rdata}, 8'hA5);
        tick();

        // Reset during EXEC of a write
        reqA = 1; weA = 1; addrA = 3; wdataA = 8'hFF;
        tick();
        chk("t5_en_pre", {28'd0, reg_en}, 4'b1000);
        res = 1;
        #1;
        chk("t5_en_gated", {28'd0, reg_en}, 0);
        reqA = 0;
        tick();
        res = 0;
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_rdata", {24'd0, rdata}, 0);
        chk("t5_bank3", {24'd0, bank[3]}, 0);
        tick();
        chk("t5_noackA", {31'd0, ackA}, 0);
        chk("t5_noackB", {31'd0, ackB}, 0);

        // Contention after reset -> A; A changes fields while busy
        reqA = 1; weA = 1; addrA = 3; wdataA = 8'h77;
        reqB = 1; weB = 0; addrB = 3;
        push(0, 0, 0); push(1, 1, 8'h77); push(0, 0, 0);
        tick();
        chk("t6_a_din", {24'd0, reg_din}, 8'h77);
        addrA = 0; wdataA = 8'h99;
        tick(); tick(); tick();
        chk("t6_b_en", {28'd0, reg_en}, 0);
        addrA = 2; wdataA = 8'h44; addrB = 0;
        tick();
        chk("t6_b_rd", {24'd0, rdata}, 8'h77);
        reqB = 0;
        tick(); tick();
        chk("t6_a_en", {28'd0, reg_en}, 4'b0100);
        chk("t6_a_din2", {24'd0, reg_din}, 8'h44);
        reqA = 0;
        tick();
        chk("t6_rd_keep", {24'd0, rdata}, 8'h77);
        tick();
        chk("t6_bank2", {24'd0, bank[2]}, 8'h44);
        chk("t6_bank0", {24'd0, bank[0]}, 8'h22);
        chk("t6_bank3", {24'd0, bank[3]}, 8'h77);

        tick();
        chk("sb_empty", sb.size(), 0);
        chk("ack_count", acks, 14);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Two-requester controller that shares a bank of 8-bit enable registers (one `reg8a`-style register per address) between requester A and requester B. It arbitrates round-robin and latches the winning request. It then drives the bank's per-register enables and data input for one cycle, or samples the addressed register for a read. It returns a one-cycle acknowledge with read data. It sits between the requesting datapath units and the register instances of the memory unit.

## Interface
- `W`, 8, data width of each bank register
- `AW`, 2, address width; bank holds `NREG = 2**AW` registers (default 4)
- `clk` in 1 — single clock, all state updates on rising edge
- `res` in 1 — reset, synchronous, active-high
- `reqA` / `reqB` in 1 — request, level; held with its fields stable until the matching ack
- `weA` / `weB` in 1 — 1 = write, 0 = read
- `addrA` / `addrB` in AW — target register
- `wdataA` / `wdataB` in W — write data
- `ackA` / `ackB` out 1 — one-cycle pulse, transaction complete
- `rdata` out W — read data, valid while ackA/ackB is high on a read
- `busy` out 1 — high whenever state ≠ IDLE
- `reg_en` out NREG — one-hot load enable to bank registers (bit i → register i)
- `reg_din` out W — data to all bank registers
- `reg_q` in NREG*W — concatenated bank outputs, register i at bits [i*W +: W]

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Else select a winner. If only one req is high, that requester wins.
  - If both are high, the requester named by priority pointer `prio` wins (`prio` = A after reset).
  - Latch winner id, we, addr and wdata; go to EXEC.
- EXEC (exactly one cycle):
  - Write: `reg_en` = one-hot(latched addr), `reg_din` = latched wdata. The register loads at the end of this cycle.
  - Read: `reg_en` = 0; capture `reg_q[addr]` into the internal rdata register at the end of this cycle.
  - Go to RESP.
- RESP (exactly one cycle):
  - Winner's ack = 1; other ack = 0.
  - `rdata` holds the captured value on reads; on writes `rdata` keeps its previous value.
  - `prio` := the non-winner.
  - Go to IDLE.
- Outside EXEC: `reg_en` = 0. `reg_din` holds the last latched wdata; it is don't-care when `reg_en` = 0 but deterministic.
- Holding req high through ack is legal. It is sampled again in the following IDLE cycle as a new, back-to-back transaction, using the field values present in that IDLE cycle.
- Fairness: when both requesters are continuously requesting, grants alternate A, B, A, B.
- Requests that arrive or change while `busy` = 1 are ignored until IDLE.

## Timing
- Transaction accepted on edge ending IDLE cycle t.
- EXEC occupies cycle t+1: the write lands in the register at the edge ending t+1, and a read samples `reg_q` at that same edge.
- RESP occupies cycle t+2: ack high, rdata valid.
- IDLE occupies cycle t+3.
- Latency is req-sampled → ack = 2 cycles; throughput is one transaction per 3 cycles.
- A read in RESP of a register written in the immediately preceding transaction returns the new value.
- Reset values, after the edge with `res` = 1:
  - state IDLE, `prio` = A
  - `ackA` = `ackB` = 0, `busy` = 0
  - `rdata` = 0, `reg_din` = 0
  - `reg_en` = 0
- `reg_en` is gated combinationally by `!res`, so a reset asserted during EXEC performs no write.
- Reset mid-transaction abandons it: no ack is issued and `prio` returns to A.
- The bank contents are not reset by this block.

## Test plan
- Reset, then reqA=1, weA=1, addrA=2, wdataA=8'hA5 → `reg_en`=4'b0100, `reg_din`=8'hA5 in cycle t+1; ackA=1 in t+2; bank reg 2 = 8'hA5.
- After the above, reqB=1, weB=0, addrB=2 → ackB=1 two cycles after sampling, `rdata`=8'hA5, ackA stays 0, `reg_en` stays 0.
- reqA and reqB held high from reset, both writing addr 0 (A: 8'h11, B: 8'h22) → acks in order A, B, A, B at cycles t+2, t+5, t+8, t+11; reg 0 alternates 8'h11/8'h22.
- Grant B, then the next contention with both high → A wins (`prio` flipped); with B alone high after B's ack → B is granted again immediately (IDLE cycle after RESP).
- reqA write addr 3 = 8'hFF, `res` asserted during the EXEC cycle → reg 3 unchanged, no ack, next cycle `busy`=0 and `rdata`=0.
- reqB read while reqA changes addr/data during `busy` → B's transaction is unaffected; A is served next using the fields present in the IDLE cycle.
